// File: rtl/xb_pkg.sv
// Shared definitions for the decode-stage writeback crossbar.
// Contents:
//   - default widths and pipeline depth used as parameter defaults by xb_wb_fwd
//   - result source index constants (broadcast plus execution units)
//   - a stage record {vld, addr, data} at the default widths
//   - a multi-hot detector for source write enables
package xb_pkg;

    localparam int XB_DATA_WIDTH    = 16;
    localparam int XB_ADDRESS_WIDTH = 4;
    localparam int XB_NUM_SRC       = 4;
    localparam int XB_NUM_RD        = 2;
    localparam int XB_WB_DEPTH      = 2;

    // Widest enable vector the multi-hot helper accepts.
    localparam int XB_MAX_SRC       = 32;

    localparam int XB_SRC_BC        = 0;
    localparam int XB_SRC_ALU       = 1;
    localparam int XB_SRC_MUL       = 2;
    localparam int XB_SRC_SHF       = 3;

    typedef struct packed {
        logic                        vld;
        logic [XB_ADDRESS_WIDTH-1:0] addr;
        logic [XB_DATA_WIDTH-1:0]    data;
    } xb_stage_t;

    // True when two or more enable bits are set (clearing the lowest set
    // bit leaves something behind).
    function automatic logic xb_multi_hot(input logic [XB_MAX_SRC-1:0] en);
        return (en & (en - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/xb_fwd_port.sv
// Single read-port forwarding mux.
// Picks, in priority order, the incoming write, then stage 0 (youngest)
// through stage DEPTH-1 (oldest), and falls back to the register-file data.
// Ports:
//   radd      read address of this port
//   rf_dt     register-file read data for this port
//   in_vld    incoming write is valid (already gated by stall and reset)
//   in_addr   incoming write address
//   in_data   incoming write data
//   stg_vld   per-stage valid, bit k = stage k
//   stg_addr  packed stage addresses, slice k = stage k
//   stg_data  packed stage data, slice k = stage k
//   dt        operand data for this port
//   hit       1 when dt comes from a forward path
module xb_fwd_port #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 4,
    parameter int WB_DEPTH      = 2
) (
    input  logic [ADDRESS_WIDTH-1:0]          radd,
    input  logic [DATA_WIDTH-1:0]             rf_dt,
    input  logic                              in_vld,
    input  logic [ADDRESS_WIDTH-1:0]          in_addr,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic [WB_DEPTH-1:0]               stg_vld,
    input  logic [WB_DEPTH*ADDRESS_WIDTH-1:0] stg_addr,
    input  logic [WB_DEPTH*DATA_WIDTH-1:0]    stg_data,
    output logic [DATA_WIDTH-1:0]             dt,
    output logic                              hit
);

    logic [DATA_WIDTH-1:0] dt_s;
    logic                  hit_s;
    logic                  match_s;

    // Walk from the oldest stage to the incoming write; each later match
    // overwrites the earlier one, so the youngest matching entry wins.
    // The last stage is included even while it is being written, because
    // the register-file read returns pre-write contents.
    always_comb begin
        dt_s    = rf_dt;
        hit_s   = 1'b0;
        match_s = 1'b0;
        for (int k = WB_DEPTH - 1; k >= 0; k--) begin
            match_s = stg_vld[k] & (stg_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] == radd);
            dt_s    = match_s ? stg_data[k*DATA_WIDTH +: DATA_WIDTH] : dt_s;
            hit_s   = hit_s | match_s;
        end
        match_s = in_vld & (in_addr == radd);
        dt_s    = match_s ? in_data : dt_s;
        hit_s   = hit_s | match_s;
    end

    assign dt  = dt_s;
    assign hit = hit_s;

endmodule

// File: rtl/xb_wb_fwd.sv
// Decode-stage writeback crossbar with forwarding.
// Selects the lowest-indexed enabled result source, carries it through a
// WB_DEPTH-stage writeback pipeline to the register file, and forwards the
// youngest in-flight result matching each read port's address.
// Ports:
//   clk_dcd        decode clock, rising edge
//   rst_dcd_n      asynchronous active-low reset
//   ps_xb_stall    1 freezes the writeback pipeline and ignores enables
//   ps_xb_w_en     per-source write enable (index 0 = broadcast)
//   ps_xb_wadd     destination address of the current write
//   src_xb_dt      packed source data, slice i = source i
//   ps_xb_radd     packed read addresses, slice r = port r
//   rf_xb_dt       packed register-file read data, slice r = port r
//   xb_dt          packed operand data (forwarded or register file)
//   xb_fwd_hit     per-port forward hit
//   xb_rf_w_En     register-file write strobe
//   xb_rf_wadd     register-file write address
//   xb_rf_dt       register-file write data
//   xb_err_multi   sticky: more than one source enabled in an accepted cycle
module xb_wb_fwd
    import xb_pkg::*;
#(
    parameter int DATA_WIDTH    = XB_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = XB_ADDRESS_WIDTH,
    parameter int NUM_SRC       = XB_NUM_SRC,
    parameter int NUM_RD        = XB_NUM_RD,
    parameter int WB_DEPTH      = XB_WB_DEPTH
) (
    input  logic                            clk_dcd,
    input  logic                            rst_dcd_n,
    input  logic                            ps_xb_stall,
    input  logic [NUM_SRC-1:0]              ps_xb_w_en,
    input  logic [ADDRESS_WIDTH-1:0]        ps_xb_wadd,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_xb_dt,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] ps_xb_radd,
    input  logic [NUM_RD*DATA_WIDTH-1:0]    rf_xb_dt,
    output logic [NUM_RD*DATA_WIDTH-1:0]    xb_dt,
    output logic [NUM_RD-1:0]               xb_fwd_hit,
    output logic                            xb_rf_w_En,
    output logic [ADDRESS_WIDTH-1:0]        xb_rf_wadd,
    output logic [DATA_WIDTH-1:0]           xb_rf_dt,
    output logic                            xb_err_multi
);

    localparam int LAST = WB_DEPTH - 1;

    typedef struct packed {
        logic                     vld;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } stage_t;

    stage_t                            stage_r [WB_DEPTH];
    logic                              err_r;

    logic                              in_vld_s;
    logic                              fwd_in_vld_s;
    logic                              multi_s;
    logic [DATA_WIDTH-1:0]             in_dt_s;
    logic [WB_DEPTH-1:0]               stg_vld_s;
    logic [WB_DEPTH*ADDRESS_WIDTH-1:0] stg_addr_s;
    logic [WB_DEPTH*DATA_WIDTH-1:0]    stg_data_s;

    // Source select: lowest set enable wins, scanning high to low so the
    // lowest index is the last to overwrite. With no enable the broadcast
    // slice is carried along with a clear valid.
    always_comb begin
        in_dt_s = src_xb_dt[XB_SRC_BC*DATA_WIDTH +: DATA_WIDTH];
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            in_dt_s = ps_xb_w_en[i] ? src_xb_dt[i*DATA_WIDTH +: DATA_WIDTH] : in_dt_s;
        end
    end

    assign in_vld_s     = (|ps_xb_w_en) & ~ps_xb_stall;
    // The incoming write must not forward while reset is held.
    assign fwd_in_vld_s = in_vld_s & rst_dcd_n;
    // Enables presented under stall are ignored; the issuer re-presents them.
    assign multi_s      = xb_multi_hot(XB_MAX_SRC'(ps_xb_w_en)) & ~ps_xb_stall;

    // Writeback pipeline: shift when not stalled, hold every stage otherwise.
    always_ff @(posedge clk_dcd or negedge rst_dcd_n) begin
        if (!rst_dcd_n) begin
            for (int k = 0; k < WB_DEPTH; k++) begin
                stage_r[k] <= '0;
            end
        end else if (!ps_xb_stall) begin
            stage_r[0] <= {in_vld_s, ps_xb_wadd, in_dt_s};
            for (int k = 1; k < WB_DEPTH; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end else begin
            for (int k = 0; k < WB_DEPTH; k++) begin
                stage_r[k] <= stage_r[k];
            end
        end
    end

    // Sticky multi-source error, cleared only by reset.
    always_ff @(posedge clk_dcd or negedge rst_dcd_n) begin
        if (!rst_dcd_n) begin
            err_r <= 1'b0;
        end else if (multi_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Flatten the stage records into packed vectors for the port muxes.
    always_comb begin
        stg_vld_s  = '0;
        stg_addr_s = '0;
        stg_data_s = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            stg_vld_s[k]                                  = stage_r[k].vld;
            stg_addr_s[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]  = stage_r[k].addr;
            stg_data_s[k*DATA_WIDTH +: DATA_WIDTH]        = stage_r[k].data;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_port
        xb_fwd_port #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .WB_DEPTH      (WB_DEPTH)
        ) u_port (
            .radd     (ps_xb_radd[r*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .rf_dt    (rf_xb_dt[r*DATA_WIDTH +: DATA_WIDTH]),
            .in_vld   (fwd_in_vld_s),
            .in_addr  (ps_xb_wadd),
            .in_data  (in_dt_s),
            .stg_vld  (stg_vld_s),
            .stg_addr (stg_addr_s),
            .stg_data (stg_data_s),
            .dt       (xb_dt[r*DATA_WIDTH +: DATA_WIDTH]),
            .hit      (xb_fwd_hit[r])
        );
    end

    // A held last stage strobes only in the cycle the stall releases, so
    // each entry is written exactly once.
    assign xb_rf_w_En   = stage_r[LAST].vld & ~ps_xb_stall;
    assign xb_rf_wadd   = stage_r[LAST].addr;
    assign xb_rf_dt     = stage_r[LAST].data;
    assign xb_err_multi = err_r;

endmodule

// File: tb/tb_xb_wb_fwd.sv
module tb_xb_wb_fwd;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NS = 4;
    localparam int NR = 2;
    localparam int D  = 2;

    logic             clk_dcd     = 1'b0;
    logic             rst_dcd_n   = 1'b0;
    logic             ps_xb_stall = 1'b0;
    logic [NS-1:0]    ps_xb_w_en  = '0;
    logic [AW-1:0]    ps_xb_wadd  = '0;
    logic [NS*DW-1:0] src_xb_dt   = '0;
    logic [NR*AW-1:0] ps_xb_radd  = '0;
    logic [NR*DW-1:0] rf_xb_dt    = '0;
    logic [NR*DW-1:0] xb_dt;
    logic [NR-1:0]    xb_fwd_hit;
    logic             xb_rf_w_En;
    logic [AW-1:0]    xb_rf_wadd;
    logic [DW-1:0]    xb_rf_dt;
    logic             xb_err_multi;

    always #5 clk_dcd = ~clk_dcd;

    xb_wb_fwd #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_SRC(NS), .NUM_RD(NR), .WB_DEPTH(D)
    ) dut (
        .clk_dcd(clk_dcd), .rst_dcd_n(rst_dcd_n), .ps_xb_stall(ps_xb_stall),
        .ps_xb_w_en(ps_xb_w_en), .ps_xb_wadd(ps_xb_wadd), .src_xb_dt(src_xb_dt),
        .ps_xb_radd(ps_xb_radd), .rf_xb_dt(rf_xb_dt), .xb_dt(xb_dt),
        .xb_fwd_hit(xb_fwd_hit), .xb_rf_w_En(xb_rf_w_En), .xb_rf_wadd(xb_rf_wadd),
        .xb_rf_dt(xb_rf_dt), .xb_err_multi(xb_err_multi)
    );

    // Reference model: in-flight writes, youngest first, bubbles included.
    typedef struct { logic vld; logic [AW-1:0] addr; logic [DW-1:0] data; } ent_t;
    // Scoreboard entry for an RF write: address, data and the advance count
    // at which it must strobe.
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int due; } wr_t;
    // Per-cycle expectation for forwarding outputs and the error flag.
    typedef struct { logic [NR-1:0] hit; logic [NR*DW-1:0] dt; logic err; } cyc_t;

    ent_t fl[$];
    wr_t  exp_wr[$];
    cyc_t exp_cyc[$];
    int   adv     = 0;
    logic err_exp = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    cyc_t mc;
    wr_t  mw;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] pick(input logic [NS-1:0] en, input logic [NS*DW-1:0] src);
        for (int i = 0; i < NS; i++) begin
            if (en[i]) return src[i*DW +: DW];
        end
        return src[DW-1:0];
    endfunction

    // Advance the model on a rising edge using the inputs held in the cycle.
    task automatic edge_update();
        ent_t e;
        @(posedge clk_dcd);
        if (rst_dcd_n && !ps_xb_stall) begin
            e.vld  = |ps_xb_w_en;
            e.addr = ps_xb_wadd;
            e.data = pick(ps_xb_w_en, src_xb_dt);
            fl.push_front(e);
            if (fl.size() > D) void'(fl.pop_back());
            adv++;
            if (e.vld) exp_wr.push_back('{e.addr, e.data, adv + D - 1});
            if ($countones(ps_xb_w_en) > 1) err_exp = 1'b1;
        end
    endtask

    // Apply inputs for this cycle and push the expected forwarding result.
    task automatic drive_push(input logic st, input logic [NS-1:0] en, input logic [AW-1:0] wadd,
                              input logic [NS*DW-1:0] src, input logic [NR*AW-1:0] radd,
                              input logic [NR*DW-1:0] rf);
        cyc_t          c;
        logic [AW-1:0] ra;
        logic [DW-1:0] d;
        logic          found;
        ps_xb_stall = st;
        ps_xb_w_en  = en;
        ps_xb_wadd  = wadd;
        src_xb_dt   = src;
        ps_xb_radd  = radd;
        rf_xb_dt    = rf;
        c.hit = '0;
        c.dt  = '0;
        for (int r = 0; r < NR; r++) begin
            ra    = radd[r*AW +: AW];
            found = 1'b0;
            d     = rf[r*DW +: DW];
            if (!st && (|en) && wadd == ra) begin
                found = 1'b1;
                d     = pick(en, src);
            end else begin
                for (int k = 0; k < fl.size(); k++) begin
                    if (fl[k].vld && fl[k].addr == ra) begin
                        found = 1'b1;
                        d     = fl[k].data;
                        break;
                    end
                end
            end
            c.hit[r]        = found;
            c.dt[r*DW +: DW] = d;
        end
        c.err = err_exp;
        exp_cyc.push_back(c);
    endtask

    task automatic cyc(input logic st, input logic [NS-1:0] en, input logic [AW-1:0] wadd,
                       input logic [NS*DW-1:0] src, input logic [NR*AW-1:0] radd,
                       input logic [NR*DW-1:0] rf);
        edge_update();
        #2;
        drive_push(st, en, wadd, src, radd, rf);
    endtask

    // Asynchronous reset in mid-cycle; pending writes are discarded.
    task automatic async_reset();
        #1 rst_dcd_n = 1'b0;
        #1;
        chk("rst_async_wen", 64'(xb_rf_w_En), 64'd0);
        chk("rst_async_hit", 64'(xb_fwd_hit), 64'd0);
        chk("rst_async_dt", 64'(xb_dt), 64'(rf_xb_dt));
        fl.delete();
        exp_wr.delete();
        exp_cyc.delete();
        err_exp = 1'b0;
        @(posedge clk_dcd);
        #2 rst_dcd_n = 1'b1;
        drive_push(1'b0, '0, '0, '0, ps_xb_radd, rf_xb_dt);
    endtask

    // Monitor: compares outputs each cycle and pops RF writes when due.
    always @(negedge clk_dcd) begin
        if (!rst_dcd_n) begin
            chk("rst_wen", 64'(xb_rf_w_En), 64'd0);
            chk("rst_wadd", 64'(xb_rf_wadd), 64'd0);
            chk("rst_wdt", 64'(xb_rf_dt), 64'd0);
            chk("rst_hit", 64'(xb_fwd_hit), 64'd0);
            chk("rst_dt", 64'(xb_dt), 64'(rf_xb_dt));
            chk("rst_err", 64'(xb_err_multi), 64'd0);
        end else begin
            if (exp_cyc.size() == 0) begin
                chk("cyc_expect_present", 64'd0, 64'd1);
            end else begin
                mc = exp_cyc.pop_front();
                chk("fwd_hit", 64'(xb_fwd_hit), 64'(mc.hit));
                chk("fwd_dt", 64'(xb_dt), 64'(mc.dt));
                chk("err_multi", 64'(xb_err_multi), 64'(mc.err));
            end
            if (exp_wr.size() > 0 && exp_wr[0].due == adv && !ps_xb_stall) begin
                mw = exp_wr.pop_front();
                chk("rf_strobe", 64'(xb_rf_w_En), 64'd1);
                chk("rf_wadd", 64'(xb_rf_wadd), 64'(mw.addr));
                chk("rf_wdt", 64'(xb_rf_dt), 64'(mw.data));
            end else begin
                chk("rf_no_strobe", 64'(xb_rf_w_En), 64'd0);
            end
        end
    end

    logic [NR*DW-1:0] rfc;
    logic [NS-1:0]    ren;
    logic [NS*DW-1:0] rsrc;
    logic [NR*AW-1:0] rradd;

    initial begin
        rfc = {16'hCAFE, 16'hBEEF};
        repeat (2) @(negedge clk_dcd);
        @(posedge clk_dcd);
        #2 rst_dcd_n = 1'b1;
        drive_push(1'b0, '0, '0, '0, '0, rfc);

        // Latency: alu write to 5, forwarded in issue cycle and each stage.
        cyc(1'b0, 4'b0010, 4'd5, {16'h0, 16'h0, 16'h1234, 16'h0}, {4'd0, 4'd5}, rfc);
        cyc(1'b0, 4'b0000, 4'd0, '0, {4'd0, 4'd5}, rfc);
        cyc(1'b0, 4'b0000, 4'd0, '0, {4'd0, 4'd5}, rfc);
        cyc(1'b0, 4'b0000, 4'd0, '0, {4'd0, 4'd5}, rfc);

        // Youngest wins: two bc writes to 3.
        cyc(1'b0, 4'b0001, 4'd3, {48'h0, 16'h000A}, {4'd3, 4'd0}, rfc);
        cyc(1'b0, 4'b0001, 4'd3, {48'h0, 16'h000B}, {4'd3, 4'd0}, rfc);
        cyc(1'b0, 4'b0000, 4'd0, '0, {4'd3, 4'd0}, rfc);
        cyc(1'b0, 4'b0000, 4'd0, '0, {4'd3, 4'd0}, rfc);

        // Stall with an entry in the last stage and bc presented meanwhile.
        cyc(1'b0, 4'b0100, 4'd9, {16'h0, 16'h5555, 32'h0}, {4'd2, 4'd9}, rfc);
        cyc(1'b0, 4'b0000, 4'd0, '0, {4'd2, 4'd9}, rfc);
        repeat (3) cyc(1'b1, 4'b0001, 4'd2, {48'h0, 16'h7777}, {4'd2, 4'd9}, rfc);
        repeat (3) cyc(1'b0, 4'b0000, 4'd0, '0, {4'd2, 4'd9}, rfc);

        // Miss: nothing in flight for 7.
        cyc(1'b0, 4'b0000, 4'd0, '0, {4'd0, 4'd7}, rfc);

        // Multi-hot: mul and alu together, alu data used, error sticky.
        cyc(1'b0, 4'b0110, 4'd6, {16'h0, 16'h0002, 16'h0001, 16'h0}, {4'd6, 4'd6}, rfc);
        repeat (4) cyc(1'b0, 4'b0000, 4'd0, '0, {4'd6, 4'd6}, rfc);

        // Reset mid-flight with two valid entries.
        cyc(1'b0, 4'b0010, 4'd4, {32'h0, 16'h4444, 16'h0}, {4'd4, 4'd8}, rfc);
        cyc(1'b0, 4'b1000, 4'd8, {16'h8888, 48'h0}, {4'd4, 4'd8}, rfc);
        async_reset();
        repeat (3) cyc(1'b0, 4'b0000, 4'd0, '0, {4'd4, 4'd8}, rfc);

        // Randomised traffic on a narrow address range.
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 75) begin
                async_reset();
            end else begin
                if ($urandom_range(0, 99) < 30) ren = '0;
                else if ($urandom_range(0, 99) < 93) ren = NS'(1) << $urandom_range(0, NS - 1);
                else ren = 4'($urandom) | (4'b0011 << $urandom_range(0, 2));
                rsrc  = {$urandom, $urandom};
                rradd = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
                cyc(($urandom_range(0, 99) < 20), ren, AW'($urandom_range(0, 3)), rsrc, rradd,
                    {16'($urandom), 16'($urandom)});
            end
        end

        repeat (D + 2) cyc(1'b0, 4'b0000, 4'd0, '0, '0, rfc);
        @(negedge clk_dcd);
        chk("drain", 64'(exp_wr.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
